small_alu_writeback: RTL and testbench

SMALL_ALU_WRITEBACK -- requirements
Module: small_alu_writeback

---
 rtl/smallalu_pkg.sv | 19 +
 rtl/small_alu_writeback.sv | 116 +++++++++++
 tb/tb_small_alu_writeback.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/smallalu_pkg.sv
// rtl/smallalu_pkg.sv - shared types and constants for the ALU writeback block
// Contents:
//   reg_t      : one register-file entry (16 bits)
//   reg_idx_t  : register index (2 bits)
//   wb_state_t : writeback FSM states (IDLE, WR_HI)
//   NUM_REGS   : register count
package smallalu_pkg;

    localparam int NUM_REGS = 4;

    typedef logic [15:0] reg_t;
    typedef logic [1:0]  reg_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        WR_HI = 1'b1
    } wb_state_t;

endpackage

// File: rtl/small_alu_writeback.sv
// rtl/small_alu_writeback.sv - ALU result writeback into a 4-entry register file
// Accepts narrow (16-bit), byte (8-bit) and wide (32-bit) ALU results and
// writes them into the register file. A wide result writes its low half on
// the accept edge and its high half into the next register (index wraps) on
// the following edge, during which no new result is accepted.
//
// Configuration macro:
//   SMALL_ALU_WB_SIGN_EXT_EN : defined -> byte results sign-extended from bit 7
//                              undefined -> byte results zero-extended
// Ports:
//   clk       in   clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   in_valid  in   producer offers a result
//   in_ready  out  block can accept a result (IDLE state)
//   in_dest   in   destination register index
//   in_lo     in   low half of the result, or the whole result
//   in_hi     in   high half, used only for wide results
//   in_wide   in   32-bit result spanning two registers
//   in_byte   in   only in_lo[7:0] is meaningful
//   R         out  register file contents
//   busy      out  high-half write pending (WR_HI state)
//   wb_count  out  count of completed register writes, wraps at 256
module small_alu_writeback #(
    parameter int NUM_REGS = 4,
    parameter int REG_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [1:0]                     in_dest,
    input  logic [REG_W-1:0]               in_lo,
    input  logic [REG_W-1:0]               in_hi,
    input  logic                           in_wide,
    input  logic                           in_byte,
    output logic [NUM_REGS-1:0][REG_W-1:0] R,
    output logic                           busy,
    output logic [7:0]                     wb_count
);

    import smallalu_pkg::reg_idx_t;
    import smallalu_pkg::wb_state_t;
    import smallalu_pkg::IDLE;
    import smallalu_pkg::WR_HI;

    wb_state_t         state_q;
    wb_state_t         state_d;
    logic [REG_W-1:0]  hi_q;
    reg_idx_t          hi_idx_q;
    logic [REG_W-1:0]  lo_val;
    logic              accept;

    assign accept = in_valid && in_ready;

    // Value written on the accept edge. Wide results take priority over the
    // byte flag, so extension applies only to narrow byte results.
    always_comb begin
        lo_val = in_lo;
        if (!in_wide && in_byte) begin
`ifdef SMALL_ALU_WB_SIGN_EXT_EN
            lo_val = {{(REG_W-8){in_lo[7]}}, in_lo[7:0]};
`else
            lo_val = {{(REG_W-8){1'b0}}, in_lo[7:0]};
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid && in_wide) begin
                    state_d = WR_HI;
                end
            end
            WR_HI: begin
                busy    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // At most one register write happens per edge: either the accepted
    // result (IDLE) or the latched high half (WR_HI), so wb_count steps by
    // at most one per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            R        <= '0;
            hi_q     <= '0;
            hi_idx_q <= '0;
            wb_count <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                R[in_dest] <= lo_val;
                wb_count   <= wb_count + 8'd1;
                if (in_wide) begin
                    hi_q     <= in_hi;
                    // 2-bit add wraps index 3 to 0
                    hi_idx_q <= in_dest + 2'd1;
                end
            end else if (state_q == WR_HI) begin
                R[hi_idx_q] <= hi_q;
                wb_count    <= wb_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_small_alu_writeback.sv
// tb/tb_small_alu_writeback.sv - scoreboard testbench for small_alu_writeback
module tb_small_alu_writeback;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_dest;
    logic [15:0]       in_lo;
    logic [15:0]       in_hi;
    logic              in_wide;
    logic              in_byte;
    logic [3:0][15:0]  R;
    logic              busy;
    logic [7:0]        wb_count;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0][15:0] r;
        logic [7:0]       cnt;
    } snap_t;

    snap_t exp_q[$];

    // reference register file and write counter
    logic [15:0] model_r [4];
    int          model_cnt;

    small_alu_writeback #(.NUM_REGS(4), .REG_W(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_dest  (in_dest),
        .in_lo    (in_lo),
        .in_hi    (in_hi),
        .in_wide  (in_wide),
        .in_byte  (in_byte),
        .R        (R),
        .busy     (busy),
        .wb_count (wb_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] ext8(logic [7:0] b);
`ifdef SMALL_ALU_WB_SIGN_EXT_EN
        return {{8{b[7]}}, b};
`else
        return {8'h00, b};
`endif
    endfunction

    function automatic void model_write(int idx, logic [15:0] v);
        snap_t s;
        model_r[idx] = v;
        model_cnt    = (model_cnt + 1) % 256;
        for (int i = 0; i < 4; i++) s.r[i] = model_r[i];
        s.cnt = 8'(model_cnt);
        exp_q.push_back(s);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) model_r[i] = 16'h0000;
        model_cnt = 0;
        exp_q.delete();
    endfunction

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic issue(input logic [1:0] d, input logic [15:0] lo, input logic [15:0] hi,
                         input logic w, input logic b);
        int guard = 0;
        in_valid = 1'b1;
        in_dest  = d;
        in_lo    = lo;
        in_hi    = hi;
        in_wide  = w;
        in_byte  = b;
        while (!in_ready && guard < 8) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 64'(in_ready), 64'd1);
        end else begin
            if (w) begin
                model_write(int'(d), lo);
                model_write((int'(d) + 1) % 4, hi);
            end else begin
                model_write(int'(d), b ? ext8(lo[7:0]) : lo);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    // monitor: every change of wb_count is one register write
    initial begin
        logic [7:0] last_cnt;
        snap_t      e;
        last_cnt = 8'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_cnt = wb_count;
            end else if (wb_count !== last_cnt) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", 64'(wb_count), 64'(last_cnt));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_regs", 64'(R), 64'(e.r));
                    chk("sb_count", 64'(wb_count), 64'(e.cnt));
                end
                last_cnt = wb_count;
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_dest  = 2'd0;
        in_lo    = 16'h0;
        in_hi    = 16'h0;
        in_wide  = 1'b0;
        in_byte  = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_regs", 64'(R), 64'd0);
        chk("rst_count", 64'(wb_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", 64'(in_ready), 64'd1);

        // narrow write
        issue(2'd2, 16'h1234, 16'h0, 1'b0, 1'b0);
        chk("narrow_r2", 64'(R[2]), 64'h1234);
        chk("narrow_cnt", 64'(wb_count), 64'd1);
        chk("narrow_ready", 64'(in_ready), 64'd1);

        // wide write with index wrap
        issue(2'd3, 16'hBEEF, 16'hDEAD, 1'b1, 1'b0);
        chk("wide_r3", 64'(R[3]), 64'hBEEF);
        chk("wide_busy", 64'(busy), 64'd1);
        chk("wide_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        chk("wide_r0", 64'(R[0]), 64'hDEAD);
        chk("wide_cnt", 64'(wb_count), 64'd3);
        chk("wide_idle", 64'(busy), 64'd0);

        // byte extension
        issue(2'd1, 16'h0080, 16'h0, 1'b0, 1'b1);
`ifdef SMALL_ALU_WB_SIGN_EXT_EN
        chk("byte_r1", 64'(R[1]), 64'hFF80);
`else
        chk("byte_r1", 64'(R[1]), 64'h0080);
`endif
        // wide overrides byte flag
        issue(2'd1, 16'h00C3, 16'h7777, 1'b1, 1'b1);
        chk("wide_over_byte", 64'(R[1]), 64'h00C3);

        // stall: in_valid held during WR_HI
        issue(2'd1, 16'hAAAA, 16'h1111, 1'b1, 1'b0);
        in_valid = 1'b1;
        in_dest  = 2'd0;
        in_lo    = 16'h5555;
        in_wide  = 1'b0;
        in_byte  = 1'b0;
        @(negedge clk);
        chk("stall_no_write", 64'(R[0]), 64'hDEAD);
        chk("stall_r2", 64'(R[2]), 64'h1111);
        issue(2'd0, 16'h5555, 16'h0, 1'b0, 1'b0);
        chk("stall_r0", 64'(R[0]), 64'h5555);

        // reset during WR_HI
        issue(2'd0, 16'h4242, 16'h9999, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_regs", 64'(R), 64'd0);
        chk("midrst_count", 64'(wb_count), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_r1", 64'(R[1]), 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd1);

        // 256 narrow writes wrap the counter
        for (int i = 0; i < 256; i++)
            issue(2'($urandom_range(0, 3)), 16'($urandom), 16'h0, 1'b0, 1'($urandom_range(0, 1)));
        chk("cnt_wrap", 64'(wb_count), 64'd0);

        // randomized mix with idle gaps
        for (int i = 0; i < 300; i++) begin
            issue(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
